multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore finite state machine (FSM) that sequences a multi-cycle version of the team's MIPS-subset datapath.
- Supported instructions: add (R-type), addi, lw, sw, beq, j, hlt.
- Sits between the instruction register opcode field and the shared ALU, register-file and single-port memory controls.
- Memory accesses use a req/ready handshake.
- Maintains the cycle and instruction counters that the end-of-run halt report reads.

Parameters:
- CNT_W, 32, width of the cycles and instructions counters (wrap modulo 2^CNT_W).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces the FETCH state and clears counters.
- opcode  in  6  instruction register bits [31:26]; valid from the DECODE state onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pcwrite  out  1  PC load enable (beq condition already folded in).
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load enable.
- regdest  out  1  register-file write address select: 1 = rd, 0 = rt.
- memtoreg  out  1  register-file write data select: 1 = memory data register, 0 = ALUOut.
- regwrite  out  1  register-file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  out  2  00 = add, 01 = subtract, 10 = decode funct.
- illegal  out  1  one-cycle flag for an unsupported opcode.
- halted  out  1  high while in the HALT state.
- cycles  out  CNT_W  clock cycles executed.
- instructions  out  CNT_W  instructions retired.

Behaviour:
- Output timing: all control outputs are decoded from the state register only. The exceptions are pcwrite and irwrite (also depend on mem_ready and zero) and illegal (depends on opcode).
- Default: any output not listed for a state is 0.
- Reset: state = FETCH, cycles = 0, instructions = 0. Reset applied mid-instruction abandons it with no retirement count.
- FETCH:
  - memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> RTYPE_EX
  - 001000 -> ADDI_EX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 000010 -> JUMP
  - 111111 -> HALT
  - any other opcode: illegal = 1 for this cycle, next state FETCH, not counted as an instruction.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: memread = 1, iord = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdest = 0. Next state FETCH.
- MEMWR: memwrite = 1, iord = 1. Waits for mem_ready, then goes to FETCH.
- RTYPE_EX: alusrca = 1, alusrcb = 00, aluop = 10. Next state RTYPE_WB.
- RTYPE_WB: regwrite = 1, regdest = 1. Next state FETCH.
- ADDI_EX: alusrca = 1, alusrcb = 10, aluop = 00. Next state ADDI_WB.
- ADDI_WB: regwrite = 1, regdest = 0. Next state FETCH.
- BEQ: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, pcwrite = zero. Next state FETCH.
- JUMP: pcsrc = 10, pcwrite = 1. Next state FETCH.
- HALT: halted = 1, all other controls 0. Stays in HALT until reset; inputs are ignored.
- cycles: increments on every clock edge while not in HALT and reset is low, including memory wait cycles.
- instructions: increments on the edge that enters FETCH from MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BEQ or JUMP, and on the edge that enters HALT.
- Latency with mem_ready tied high:
  - add, addi, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
  - each low-mem_ready cycle in a memory state adds 1.
- Both counters wrap silently at 2^CNT_W.

Decomposition:
- Package mc_ctrl_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HLT;
  - state enumeration (13 states);
  - PCSRC_* encodings, ALUSRCB_* encodings, ALUOP_* encodings.
- One sub-module, perf_counter (parameter CNT_W; inputs clk, reset, inc; output count). Instantiated twice, once for cycles and once for instructions.

Test Plan:
- Reset then addi with mem_ready = 1 -> states FETCH, DECODE, ADDI_EX, ADDI_WB, FETCH. regwrite = 1 only in the 4th cycle with regdest = 0. cycles = 4, instructions = 1.
- lw with mem_ready held low for 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total. memtoreg = 1 and regwrite = 1 only in MEMWB. irwrite asserted exactly once.
- beq with zero = 1, then beq with zero = 0 -> pcwrite = 1 with pcsrc = 01 in the first BEQ cycle, pcwrite = 0 in the second. Each takes 3 cycles. instructions = 2.
- Opcode 6'b110000 -> illegal pulses for 1 cycle in DECODE, FETCH follows, instructions unchanged, cycles += 2.
- Sequence add, sw, j, hlt -> halted = 1, counters freeze at cycles = 13 and instructions = 4 for 20 more clocks.
- reset asserted during MEMRD -> next cycle state = FETCH, all outputs at FETCH values, counters = 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, FSM states and datapath mux/ALU select codes.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTYPE_EX,
      S_RTYPE_WB,
      S_ADDI_EX,
      S_ADDI_WB,
      S_BEQ,
      S_JUMP,
      S_HALT
   } state_e;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUSRCB_RT      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Final state of each instruction class; leaving it for FETCH retires the instruction.
   function automatic logic is_last_state(state_e s);
      return s inside {S_MEMWB, S_MEMWR, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_JUMP};
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if;

   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       pcwrite;
   logic [1:0] pcsrc;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       regdest;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic       illegal;
   logic       halted;

   modport master (
      input  opcode, zero, mem_ready,
      output pcwrite, pcsrc, iord, memread, memwrite, irwrite, regdest,
             memtoreg, regwrite, alusrca, alusrcb, aluop, illegal, halted
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pcwrite, pcsrc, iord, memread, memwrite, irwrite, regdest,
             memtoreg, regwrite, alusrca, alusrcb, aluop, illegal, halted
   );

endinterface

// File: rtl/multicycle_ctrl_perf_counter.sv
// Free-running event counter with synchronous clear; wraps silently at 2^CNT_W.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multi-cycle MIPS-subset datapath (add, addi, lw, sw, beq, j, hlt)
// with cycle and retired-instruction counters for the halt report.
module multicycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   multicycle_ctrl_if.master  bus,
   output logic [CNT_W-1:0]   cycles,
   output logic [CNT_W-1:0]   instructions
);

   state_e state;
   state_e next_state;
   logic   retire;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= next_state;
   end

   // NOTE: every output gets a default before the case, so no path infers a latch.
   always_comb begin
      next_state   = state;
      bus.pcwrite  = 1'b0;
      bus.pcsrc    = PCSRC_ALU;
      bus.iord     = 1'b0;
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regdest  = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = ALUSRCB_RT;
      bus.aluop    = ALUOP_ADD;
      bus.illegal  = 1'b0;
      bus.halted   = 1'b0;

      case (state)
         S_FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = ALUSRCB_FOUR;
            bus.irwrite = bus.mem_ready;
            bus.pcwrite = bus.mem_ready;
            if (bus.mem_ready)
               next_state = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut here.
            bus.alusrcb = ALUSRCB_IMM_SH2;
            case (bus.opcode)
               OP_RTYPE:     next_state = S_RTYPE_EX;
               OP_ADDI:      next_state = S_ADDI_EX;
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_BEQ:       next_state = S_BEQ;
               OP_J:         next_state = S_JUMP;
               OP_HLT:       next_state = S_HALT;
               default: begin
                  bus.illegal = 1'b1;
                  next_state  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = ALUSRCB_IMM;
            next_state  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
            if (bus.mem_ready)
               next_state = S_MEMWB;
         end
         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
            next_state   = S_FETCH;
         end
         S_MEMWR: begin
            bus.memwrite = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready)
               next_state = S_FETCH;
         end
         S_RTYPE_EX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALUOP_FUNCT;
            next_state  = S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            bus.regwrite = 1'b1;
            bus.regdest  = 1'b1;
            next_state   = S_FETCH;
         end
         S_ADDI_EX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = ALUSRCB_IMM;
            next_state  = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            bus.regwrite = 1'b1;
            next_state   = S_FETCH;
         end
         S_BEQ: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALUOP_SUB;
            bus.pcsrc   = PCSRC_ALUOUT;
            bus.pcwrite = bus.zero;
            next_state  = S_FETCH;
         end
         S_JUMP: begin
            bus.pcsrc   = PCSRC_JUMP;
            bus.pcwrite = 1'b1;
            next_state  = S_FETCH;
         end
         S_HALT: begin
            bus.halted = 1'b1;
         end
         default: next_state = S_FETCH;
      endcase
   end

   // hlt retires on entry to HALT; illegal opcodes return to FETCH from DECODE and never retire.
   always_comb begin
      retire = (next_state == S_FETCH && is_last_state(state)) ||
               (state == S_DECODE && next_state == S_HALT);
   end

   perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (state != S_HALT),
      .count (cycles)
   );

   perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (retire),
      .count (instructions)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-cycle control vectors and counter values.
module tb_multicycle_ctrl;

   typedef enum int {
      T_FETCH, T_DECODE, T_DECODE_ILL, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
      T_RTEX, T_RTWB, T_ADEX, T_ADWB, T_BEQ, T_JUMP, T_HALT
   } tb_st_e;

   localparam logic [5:0] C_ADD  = 6'b000000;
   localparam logic [5:0] C_ADDI = 6'b001000;
   localparam logic [5:0] C_LW   = 6'b100011;
   localparam logic [5:0] C_SW   = 6'b101011;
   localparam logic [5:0] C_BEQ  = 6'b000100;
   localparam logic [5:0] C_J    = 6'b000010;
   localparam logic [5:0] C_HLT  = 6'b111111;
   localparam logic [5:0] C_BAD  = 6'b110000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cycles;
   logic [31:0] instructions;
   logic [16:0] ctl;
   int          total = 0;
   int          bad = 0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .cycles       (cycles),
      .instructions (instructions)
   );

   always #5 clk = ~clk;

   assign ctl = {bus.pcwrite, bus.pcsrc, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
                 bus.regdest, bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb,
                 bus.aluop, bus.illegal, bus.halted};

   // Expected control vector for a state, written from the state/output table.
   function automatic logic [16:0] expv(tb_st_e s, logic mr, logic z);
      logic       pw = 0, io = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0;
      logic       sa = 0, ill = 0, hlt = 0;
      logic [1:0] ps = 2'b00, sb = 2'b00, op = 2'b00;
      case (s)
         T_FETCH:      begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
         T_DECODE:     sb = 2'b11;
         T_DECODE_ILL: begin sb = 2'b11; ill = 1; end
         T_MEMADR:     begin sa = 1; sb = 2'b10; end
         T_MEMRD:      begin mrd = 1; io = 1; end
         T_MEMWB:      begin rw = 1; m2r = 1; end
         T_MEMWR:      begin mwr = 1; io = 1; end
         T_RTEX:       begin sa = 1; op = 2'b10; end
         T_RTWB:       begin rw = 1; rd = 1; end
         T_ADEX:       begin sa = 1; sb = 2'b10; end
         T_ADWB:       rw = 1;
         T_BEQ:        begin sa = 1; op = 2'b01; ps = 2'b01; pw = z; end
         T_JUMP:       begin ps = 2'b10; pw = 1; end
         T_HALT:       hlt = 1;
         default:      ;
      endcase
      return {pw, ps, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, op, ill, hlt};
   endfunction

   task automatic drive(input logic [5:0] op, input logic mr, input logic z);
      bus.opcode    = op;
      bus.mem_ready = mr;
      bus.zero      = z;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(C_ADD, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] e;
      do_reset();
      drive(C_ADDI, 1'b0, 1'b0);
      e = expv(T_FETCH, 1'b0, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", ctl, e); end
      total++; if (cycles !== 32'd0) begin bad++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
      total++; if (instructions !== 32'd0) begin bad++; $display("FAIL reset_instr got=%0d exp=0", instructions); end
      drive(C_ADDI, 1'b1, 1'b0);
      e = expv(T_FETCH, 1'b1, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL reset_fetch_ready got=%h exp=%h", ctl, e); end
   endtask

   task automatic test_addi();
      tb_st_e seq [4] = '{T_FETCH, T_DECODE, T_ADEX, T_ADWB};
      logic [16:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(C_ADDI, 1'b1, 1'b0);
         e = expv(seq[i], 1'b1, 1'b0);
         total++; if (ctl !== e) begin bad++; $display("FAIL addi_c%0d got=%h exp=%h", i, ctl, e); end
         tick();
      end
      drive(C_ADDI, 1'b1, 1'b0);
      e = expv(T_FETCH, 1'b1, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL addi_back_to_fetch got=%h exp=%h", ctl, e); end
      total++; if (cycles !== 32'd4) begin bad++; $display("FAIL addi_cycles got=%0d exp=4", cycles); end
      total++; if (instructions !== 32'd1) begin bad++; $display("FAIL addi_instr got=%0d exp=1", instructions); end
   endtask

   task automatic test_lw_wait();
      tb_st_e seq [10] = '{T_FETCH, T_FETCH, T_FETCH, T_DECODE, T_MEMADR,
                           T_MEMRD, T_MEMRD, T_MEMRD, T_MEMRD, T_MEMWB};
      logic   mr  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [16:0] e;
      int ir_cnt = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(C_LW, mr[i], 1'b0);
         e = expv(seq[i], mr[i], 1'b0);
         total++; if (ctl !== e) begin bad++; $display("FAIL lw_c%0d got=%h exp=%h", i, ctl, e); end
         if (bus.irwrite === 1'b1) ir_cnt++;
         tick();
      end
      drive(C_LW, 1'b0, 1'b0);
      e = expv(T_FETCH, 1'b0, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL lw_back_to_fetch got=%h exp=%h", ctl, e); end
      total++; if (ir_cnt !== 1) begin bad++; $display("FAIL lw_irwrite_count got=%0d exp=1", ir_cnt); end
      total++; if (cycles !== 32'd10) begin bad++; $display("FAIL lw_cycles got=%0d exp=10", cycles); end
      total++; if (instructions !== 32'd1) begin bad++; $display("FAIL lw_instr got=%0d exp=1", instructions); end
   endtask

   task automatic test_beq();
      tb_st_e seq [3] = '{T_FETCH, T_DECODE, T_BEQ};
      logic [16:0] e;
      logic z;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         z = (k == 0);
         for (int i = 0; i < 3; i++) begin
            drive(C_BEQ, 1'b1, z);
            e = expv(seq[i], 1'b1, z);
            total++; if (ctl !== e) begin bad++; $display("FAIL beq%0d_c%0d got=%h exp=%h", k, i, ctl, e); end
            tick();
         end
      end
      total++; if (cycles !== 32'd6) begin bad++; $display("FAIL beq_cycles got=%0d exp=6", cycles); end
      total++; if (instructions !== 32'd2) begin bad++; $display("FAIL beq_instr got=%0d exp=2", instructions); end
   endtask

   task automatic test_illegal();
      logic [31:0] c0, i0;
      logic [16:0] e;
      c0 = cycles;
      i0 = instructions;
      drive(C_BAD, 1'b1, 1'b0);
      e = expv(T_FETCH, 1'b1, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL ill_fetch got=%h exp=%h", ctl, e); end
      tick();
      drive(C_BAD, 1'b1, 1'b0);
      e = expv(T_DECODE_ILL, 1'b1, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL ill_decode got=%h exp=%h", ctl, e); end
      tick();
      drive(C_ADDI, 1'b0, 1'b0);
      e = expv(T_FETCH, 1'b0, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL ill_refetch got=%h exp=%h", ctl, e); end
      total++; if (cycles !== c0 + 32'd2) begin bad++; $display("FAIL ill_cycles got=%0d exp=%0d", cycles, c0 + 32'd2); end
      total++; if (instructions !== i0) begin bad++; $display("FAIL ill_instr got=%0d exp=%0d", instructions, i0); end
   endtask

   task automatic test_halt();
      tb_st_e     seq [13] = '{T_FETCH, T_DECODE, T_RTEX, T_RTWB,
                               T_FETCH, T_DECODE, T_MEMADR, T_MEMWR,
                               T_FETCH, T_DECODE, T_JUMP,
                               T_FETCH, T_DECODE};
      logic [5:0] ops [13] = '{C_ADD, C_ADD, C_ADD, C_ADD, C_SW, C_SW, C_SW, C_SW,
                               C_J, C_J, C_J, C_HLT, C_HLT};
      logic [16:0] e;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(ops[i], 1'b1, 1'b0);
         e = expv(seq[i], 1'b1, 1'b0);
         total++; if (ctl !== e) begin bad++; $display("FAIL prog_c%0d got=%h exp=%h", i, ctl, e); end
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         drive(6'(i * 7), 1'(i), 1'(i >> 1));
         e = expv(T_HALT, 1'b0, 1'b0);
         total++; if (ctl !== e) begin bad++; $display("FAIL halt_c%0d got=%h exp=%h", i, ctl, e); end
         total++; if (cycles !== 32'd13) begin bad++; $display("FAIL halt_cycles_c%0d got=%0d exp=13", i, cycles); end
         total++; if (instructions !== 32'd4) begin bad++; $display("FAIL halt_instr_c%0d got=%0d exp=4", i, instructions); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      tb_st_e seq [4] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMRD};
      logic   mr  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [16:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(C_LW, mr[i], 1'b0);
         e = expv(seq[i], mr[i], 1'b0);
         total++; if (ctl !== e) begin bad++; $display("FAIL rmid_c%0d got=%h exp=%h", i, ctl, e); end
         if (i < 3) tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(C_LW, 1'b0, 1'b0);
      e = expv(T_FETCH, 1'b0, 1'b0);
      total++; if (ctl !== e) begin bad++; $display("FAIL rmid_fetch got=%h exp=%h", ctl, e); end
      total++; if (cycles !== 32'd0) begin bad++; $display("FAIL rmid_cycles got=%0d exp=0", cycles); end
      total++; if (instructions !== 32'd0) begin bad++; $display("FAIL rmid_instr got=%0d exp=0", instructions); end
   endtask

   initial begin
      bus.opcode    = C_ADD;
      bus.mem_ready = 1'b0;
      bus.zero      = 1'b0;
      test_reset();
      test_addi();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
